// File: rtl/bus_main_pkg.sv
// bus_main_pkg: shared types and constants for the bus_main arbiter.
//   - BUS_CMD_READ / BUS_CMD_WRITE : downstream bus_cmd encoding
//   - state_e  : one-hot controller state
//   - owner_e  : requester identity (fetch1 / memory1)
//   - ctrl_t   : registered controller state (state, owner, last_grant)
package bus_main_pkg;

  localparam logic BUS_CMD_READ  = 1'b1;
  localparam logic BUS_CMD_WRITE = 1'b0;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_CMD   = 5'b00010,
    ST_RDATA = 5'b00100,
    ST_WDATA = 5'b01000,
    ST_ERR   = 5'b10000
  } state_e;

  typedef enum logic {
    OWN_FE1  = 1'b0,
    OWN_MEM1 = 1'b1
  } owner_e;

  typedef struct packed {
    state_e state;
    owner_e owner;
    owner_e last_grant;
  } ctrl_t;

  // last_grant starts at fe1 so that mem1 takes the first tie.
  localparam ctrl_t CTRL_RESET = '{state: ST_IDLE, owner: OWN_FE1, last_grant: OWN_FE1};

endpackage

// File: rtl/bus_main.sv
// bus_main: two-requester (fetch1, memory1) arbiter onto one downstream bus.
//   Parameter FAIR : 1 = round-robin on ties, 0 = mem1 always wins ties.
//   clk_core, reset          : core clock, synchronous active-high reset
//   fe1_*  / mem1_*          : requester command, read-ready, error-ack
//   mem1_w*                  : memory1 write data channel (fe1 only reads)
//   bmain_*_fe1 / _mem1      : per-requester responses, zero for non-owner
//   bmain_rdata/bmain_rlast  : read data broadcast to both requesters
//   bus_*                    : downstream command/write/read/error channels
module bus_main
  import bus_main_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic        clk_core,
  input  logic        reset,
  input  logic        fe1_cvalid,
  input  logic        fe1_cmd,
  input  logic [28:2] fe1_addr,
  input  logic        fe1_rready,
  input  logic        fe1_eack,
  input  logic        mem1_cvalid,
  input  logic        mem1_cmd,
  input  logic [28:2] mem1_addr,
  input  logic        mem1_rready,
  input  logic        mem1_eack,
  input  logic        mem1_wvalid,
  input  logic        mem1_wlast,
  input  logic [31:0] mem1_wdata,
  output logic        bmain_cready_fe1,
  output logic        bmain_rvalid_fe1,
  output logic        bmain_error_fe1,
  output logic        bmain_cready_mem1,
  output logic        bmain_rvalid_mem1,
  output logic        bmain_wready_mem1,
  output logic        bmain_error_mem1,
  output logic        bmain_rlast,
  output logic [31:0] bmain_rdata,
  output logic        bus_cvalid,
  output logic        bus_cmd,
  output logic [28:2] bus_addr,
  input  logic        bus_cready,
  output logic        bus_wvalid,
  output logic        bus_wlast,
  output logic [31:0] bus_wdata,
  input  logic        bus_wready,
  input  logic        bus_rvalid,
  input  logic        bus_rlast,
  input  logic [31:0] bus_rdata,
  output logic        bus_rready,
  input  logic        bus_error,
  output logic        bus_eack
);

  ctrl_t ctrl_q;
  ctrl_t ctrl_d;

  logic        own_mem1;
  logic        own_cvalid;
  logic        own_cmd;
  logic [28:2] own_addr;
  logic        own_rready;
  logic        own_eack;

  // Winner of a new grant: a sole requester wins; a tie goes to the
  // requester that did not win last time (FAIR) or always to mem1.
  function automatic owner_e pick_winner(input logic fe1_req, input logic mem1_req,
                                         input owner_e last);
    owner_e win;
    if (fe1_req && mem1_req) begin
      if (FAIR != 0) begin
        win = (last == OWN_FE1) ? OWN_MEM1 : OWN_FE1;
      end else begin
        win = OWN_MEM1;
      end
    end else if (mem1_req) begin
      win = OWN_MEM1;
    end else begin
      win = OWN_FE1;
    end
    return win;
  endfunction

  // Controller state register.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      ctrl_q <= CTRL_RESET;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // Next-state logic and owner-steered output routing.
  always_comb begin
    ctrl_d            = ctrl_q;
    bmain_cready_fe1  = 1'b0;
    bmain_rvalid_fe1  = 1'b0;
    bmain_error_fe1   = 1'b0;
    bmain_cready_mem1 = 1'b0;
    bmain_rvalid_mem1 = 1'b0;
    bmain_wready_mem1 = 1'b0;
    bmain_error_mem1  = 1'b0;
    bmain_rlast       = bus_rlast;
    bmain_rdata       = bus_rdata;
    bus_cvalid        = 1'b0;
    bus_cmd           = BUS_CMD_WRITE;
    bus_addr          = 27'd0;
    bus_wvalid        = 1'b0;
    bus_wlast         = 1'b0;
    bus_wdata         = 32'd0;
    bus_rready        = 1'b0;
    bus_eack          = 1'b0;

    own_mem1   = (ctrl_q.owner == OWN_MEM1);
    own_cvalid = own_mem1 ? mem1_cvalid : fe1_cvalid;
    // fetch1 has no write path, so its command is always a read.
    own_cmd    = own_mem1 ? mem1_cmd    : BUS_CMD_READ;
    own_addr   = own_mem1 ? mem1_addr   : fe1_addr;
    own_rready = own_mem1 ? mem1_rready : fe1_rready;
    own_eack   = own_mem1 ? mem1_eack   : fe1_eack;

    // Error handshake belongs to the owner in every non-idle state.
    if (ctrl_q.state != ST_IDLE) begin
      bus_eack = own_eack;
      if (own_mem1) begin
        bmain_error_mem1 = bus_error;
      end else begin
        bmain_error_fe1 = bus_error;
      end
    end else begin
      bus_eack = 1'b0;
    end

    case (ctrl_q.state)
      ST_IDLE: begin
        if (fe1_cvalid || mem1_cvalid) begin
          ctrl_d.owner = pick_winner(fe1_cvalid, mem1_cvalid, ctrl_q.last_grant);
          ctrl_d.state = ST_CMD;
        end else begin
          ctrl_d.state = ST_IDLE;
        end
      end
      ST_CMD: begin
        bus_cvalid = own_cvalid;
        bus_cmd    = own_cmd;
        bus_addr   = own_addr;
        if (own_mem1) begin
          bmain_cready_mem1 = bus_cready;
        end else begin
          bmain_cready_fe1 = bus_cready;
        end
        if (bus_error) begin
          ctrl_d.state = own_eack ? ST_IDLE : ST_ERR;
        end else if (!own_cvalid) begin
          // Request withdrawn before the handshake: nothing was issued.
          ctrl_d.state = ST_IDLE;
        end else if (bus_cready) begin
          ctrl_d.state      = (own_cmd == BUS_CMD_READ) ? ST_RDATA : ST_WDATA;
          ctrl_d.last_grant = ctrl_q.owner;
        end else begin
          ctrl_d.state = ST_CMD;
        end
      end
      ST_RDATA: begin
        bus_rready = own_rready;
        if (own_mem1) begin
          bmain_rvalid_mem1 = bus_rvalid;
        end else begin
          bmain_rvalid_fe1 = bus_rvalid;
        end
        // Error wins over a simultaneous last beat; length is set by rlast only.
        if (bus_error) begin
          ctrl_d.state = own_eack ? ST_IDLE : ST_ERR;
        end else if (bus_rvalid && own_rready && bus_rlast) begin
          ctrl_d.state = ST_IDLE;
        end else begin
          ctrl_d.state = ST_RDATA;
        end
      end
      ST_WDATA: begin
        bus_wvalid = mem1_wvalid;
        bus_wlast  = mem1_wlast;
        bus_wdata  = mem1_wdata;
        if (own_mem1) begin
          bmain_wready_mem1 = bus_wready;
        end else begin
          bmain_wready_mem1 = 1'b0;
        end
        if (bus_error) begin
          ctrl_d.state = own_eack ? ST_IDLE : ST_ERR;
        end else if (mem1_wvalid && bus_wready && mem1_wlast) begin
          ctrl_d.state = ST_IDLE;
        end else begin
          ctrl_d.state = ST_WDATA;
        end
      end
      ST_ERR: begin
        if (own_eack) begin
          ctrl_d.state = ST_IDLE;
        end else begin
          ctrl_d.state = ST_ERR;
        end
      end
      default: begin
        ctrl_d = CTRL_RESET;
      end
    endcase
  end

endmodule
